// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: bus widths, the default I/O
// window base, arbiter state encoding and read-owner tag encoding.
package mem_ctrl_pkg;
    localparam int ADDR_W = 32;
    localparam int BYTE_W = 8;
    localparam logic [ADDR_W-1:0] IO_BASE_DEF = 32'h0003_0000;

    typedef enum logic [1:0] {SRV_IDLE, SRV_IF, SRV_MA, SRV_TURN} srv_state_e;
    typedef enum logic [1:0] {TAG_NONE, TAG_IF, TAG_MA} rd_tag_e;
endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of the fetch port, data port, RAM and I/O signals of mem_ctrl.
// slave = controller side, master = the surrounding system / testbench.
interface mem_ctrl_if #(parameter int RAM_AW = 17) ();
    import mem_ctrl_pkg::*;

    logic [ADDR_W-1:0] if_addr_in;
    logic              if_ce_in;
    logic [BYTE_W-1:0] if_data_out;
    logic              if_stall_out;
    logic [ADDR_W-1:0] ma_addr_in;
    logic [BYTE_W-1:0] ma_data_in;
    logic              ma_rw_in;
    logic              ma_ce_in;
    logic [BYTE_W-1:0] ma_data_out;
    logic [RAM_AW-1:0] ram_addr_out;
    logic [BYTE_W-1:0] ram_data_out;
    logic              ram_we_out;
    logic [BYTE_W-1:0] ram_data_in;
    logic [BYTE_W-1:0] io_data_out;
    logic              io_valid_out;

    modport slave (
        input  if_addr_in, if_ce_in, ma_addr_in, ma_data_in, ma_rw_in, ma_ce_in, ram_data_in,
        output if_data_out, if_stall_out, ma_data_out, ram_addr_out, ram_data_out, ram_we_out,
               io_data_out, io_valid_out
    );

    modport master (
        output if_addr_in, if_ce_in, ma_addr_in, ma_data_in, ma_rw_in, ma_ce_in, ram_data_in,
        input  if_data_out, if_stall_out, ma_data_out, ram_addr_out, ram_data_out, ram_we_out,
               io_data_out, io_valid_out
    );
endinterface

// File: rtl/mem_ctrl_arb.sv
// Arbiter between the fetch and data ports: service FSM plus the combinational
// RAM owner select (data port preempts in the same cycle).
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       if_ce,
    input  logic       ma_ce,
    output srv_state_e state_q,
    output rd_tag_e    owner
);
    srv_state_e state_d;

    always_comb begin
        state_d = SRV_IDLE;
        if (rst)
            state_d = SRV_IDLE;
        else if (ma_ce)
            state_d = SRV_MA;
        else if (state_q == SRV_MA)
            state_d = SRV_TURN;
        else if (if_ce)
            state_d = SRV_IF;
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    // The turnaround cycle gives the fetch port no slot, so a late MA byte
    // can never be taken as fetch data.
    always_comb begin
        owner = TAG_NONE;
        if (ma_ce)
            owner = TAG_MA;
        else if (if_ce && state_q != SRV_TURN)
            owner = TAG_IF;
    end
endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide memory controller sharing one synchronous RAM between instruction
// fetch and data access. Define MEM_CTRL_IO_EN to decode writes >= IO_BASE to I/O.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int                RAM_AW  = 17,
    parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);
`ifdef MEM_CTRL_IO_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    srv_state_e        state_q;
    rd_tag_e           owner;
    rd_tag_e           rd_tag_d, rd_tag_q;
    logic [BYTE_W-1:0] if_hold_d, if_hold_q;
    logic [BYTE_W-1:0] ma_hold_d, ma_hold_q;
    logic [RAM_AW-1:0] ram_addr;
    logic              ma_wr, ma_io;

    mem_ctrl_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .if_ce   (bus.if_ce_in),
        .ma_ce   (bus.ma_ce_in),
        .state_q (state_q),
        .owner   (owner)
    );

    assign ma_wr = bus.ma_ce_in & bus.ma_rw_in;
    assign ma_io = IO_EN && (bus.ma_addr_in >= IO_BASE);

    always_comb begin
        ram_addr = '0;
        case (owner)
            TAG_MA:  ram_addr = bus.ma_addr_in[RAM_AW-1:0];
            TAG_IF:  ram_addr = bus.if_addr_in[RAM_AW-1:0];
            default: ram_addr = '0;
        endcase
    end

    assign bus.ram_addr_out = ram_addr;
    assign bus.ram_data_out = bus.ma_data_in;
    assign bus.ram_we_out   = ma_wr & ~ma_io & ~rst;

    // Writes issue no read, so they leave no tag behind.
    always_comb begin
        rd_tag_d = TAG_NONE;
        if (!rst) begin
            if (owner == TAG_IF)
                rd_tag_d = TAG_IF;
            else if (owner == TAG_MA && !bus.ma_rw_in)
                rd_tag_d = TAG_MA;
        end
        if_hold_d = (rd_tag_q == TAG_IF) ? bus.ram_data_in : if_hold_q;
        ma_hold_d = (rd_tag_q == TAG_MA) ? bus.ram_data_in : ma_hold_q;
        if (rst) begin
            if_hold_d = '0;
            ma_hold_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        rd_tag_q  <= rd_tag_d;
        if_hold_q <= if_hold_d;
        ma_hold_q <= ma_hold_d;
    end

    assign bus.if_data_out  = (rd_tag_q == TAG_IF) ? bus.ram_data_in : if_hold_q;
    assign bus.ma_data_out  = (rd_tag_q == TAG_MA) ? bus.ram_data_in : ma_hold_q;
    assign bus.if_stall_out = ~rst & bus.if_ce_in &
                              (bus.ma_ce_in | (state_q == SRV_TURN) | (rd_tag_q != TAG_IF));

`ifdef MEM_CTRL_IO_EN
    logic [BYTE_W-1:0] io_data_d, io_data_q;
    logic              io_valid_d, io_valid_q;

    always_comb begin
        io_valid_d = ~rst & ma_wr & ma_io;
        io_data_d  = io_valid_d ? bus.ma_data_in : io_data_q;
        if (rst)
            io_data_d = '0;
    end

    always_ff @(posedge clk) begin
        io_valid_q <= io_valid_d;
        io_data_q  <= io_data_d;
    end

    assign bus.io_valid_out = io_valid_q;
    assign bus.io_data_out  = io_data_q;
`else
    assign bus.io_valid_out = 1'b0;
    assign bus.io_data_out  = '0;
`endif
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-wide sync RAM model, fetch/data arbitration,
// turnaround, I/O decode (follows MEM_CTRL_IO_EN) and mid-transaction reset.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

`ifdef MEM_CTRL_IO_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_ctrl_if #(.RAM_AW(17)) bus ();

    mem_ctrl #(.RAM_AW(17), .IO_BASE(32'h0003_0000)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous RAM: read data appears one cycle after the address.
    logic [7:0] ram [0:131071];
    logic       ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 131072; i++) ram[i] <= 8'h00;
            ram_init <= 1'b1;
        end else if (bus.ram_we_out) begin
            ram[bus.ram_addr_out] <= bus.ram_data_out;
        end
        bus.ram_data_in <= ram[bus.ram_addr_out];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        bus.if_addr_in = '0;
        bus.if_ce_in   = 1'b0;
        bus.ma_addr_in = '0;
        bus.ma_data_in = '0;
        bus.ma_rw_in   = 1'b0;
        bus.ma_ce_in   = 1'b0;
    endtask

    task automatic ma_set(input logic rw, input logic [31:0] a, input logic [7:0] d);
        bus.ma_ce_in   = 1'b1;
        bus.ma_rw_in   = rw;
        bus.ma_addr_in = a;
        bus.ma_data_in = d;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] wd [4];
    logic [7:0] rb_exp [3];
    logic [31:0] rb_adr [3];

    initial begin
        wd = '{8'h44, 8'h33, 8'h22, 8'h11};
        idle_in();
        rst = 1'b1;

        // Reset with both ports requesting: no write, no stall.
        ma_set(1'b1, 32'h20, 8'h77);
        bus.if_ce_in = 1'b1; bus.if_addr_in = 32'h10;
        @(negedge clk);
        chk("rst_we", 32'(bus.ram_we_out), 32'd0);
        chk("rst_stall", 32'(bus.if_stall_out), 32'd0);
        nxt();
        idle_in();
        @(negedge clk);
        chk("rst_if_data", 32'(bus.if_data_out), 32'h0);
        chk("rst_ma_data", 32'(bus.ma_data_out), 32'h0);
        chk("rst_io_valid", 32'(bus.io_valid_out), 32'd0);
        chk("rst_io_data", 32'(bus.io_data_out), 32'h0);
        nxt();
        rst = 1'b0;

        // Word write at 0x100 little-endian, plus 0xAB at 0x10.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) ma_set(1'b1, 32'h100 + 32'(i), wd[i]);
            else       ma_set(1'b1, 32'h10, 8'hAB);
            @(negedge clk);
            chk("wr_we", 32'(bus.ram_we_out), 32'd1);
            chk("wr_addr", 32'(bus.ram_addr_out), (i < 4) ? 32'h100 + 32'(i) : 32'h10);
            chk("wr_data", 32'(bus.ram_data_out), (i < 4) ? 32'(wd[i]) : 32'hAB);
            nxt();
        end
        idle_in();
        nxt();

        // Byte reads: each byte arrives the cycle after its address.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) ma_set(1'b0, 32'h100 + 32'(i), 8'h00);
            else       idle_in();
            @(negedge clk);
            if (i < 4) chk("rd_addr", 32'(bus.ram_addr_out), 32'h100 + 32'(i));
            if (i < 4) chk("rd_we", 32'(bus.ram_we_out), 32'd0);
            if (i > 0) chk("rd_data", 32'(bus.ma_data_out), 32'(wd[i-1]));
            nxt();
        end
        @(negedge clk);
        chk("ma_hold", 32'(bus.ma_data_out), 32'h11);
        nxt();

        // Fetch alone from idle.
        bus.if_ce_in = 1'b1; bus.if_addr_in = 32'h10;
        @(negedge clk);
        chk("if0_addr", 32'(bus.ram_addr_out), 32'h10);
        chk("if0_stall", 32'(bus.if_stall_out), 32'd1);
        nxt();
        bus.if_addr_in = 32'h100;
        @(negedge clk);
        chk("if1_data", 32'(bus.if_data_out), 32'hAB);
        chk("if1_stall", 32'(bus.if_stall_out), 32'd0);
        nxt();
        bus.if_addr_in = 32'h101;
        @(negedge clk);
        chk("if2_data", 32'(bus.if_data_out), 32'h44);
        chk("if2_stall", 32'(bus.if_stall_out), 32'd0);
        nxt();

        // Data port preempts an active fetch stream.
        bus.if_addr_in = 32'h102;
        ma_set(1'b0, 32'h103, 8'h00);
        @(negedge clk);
        chk("pre_addr", 32'(bus.ram_addr_out), 32'h103);
        chk("pre_stall", 32'(bus.if_stall_out), 32'd1);
        chk("pre_if_data", 32'(bus.if_data_out), 32'h33);
        nxt();
        bus.ma_ce_in = 1'b0;
        @(negedge clk);
        chk("rel_ma_data", 32'(bus.ma_data_out), 32'h11);
        chk("rel_stall", 32'(bus.if_stall_out), 32'd1);
        chk("rel_addr", 32'(bus.ram_addr_out), 32'h102);
        nxt();
        @(negedge clk);
        chk("turn_stall", 32'(bus.if_stall_out), 32'd1);
        chk("turn_addr", 32'(bus.ram_addr_out), 32'h0);
        nxt();
        @(negedge clk);
        chk("res_stall", 32'(bus.if_stall_out), 32'd1);
        chk("res_addr", 32'(bus.ram_addr_out), 32'h102);
        nxt();
        @(negedge clk);
        chk("res_stall2", 32'(bus.if_stall_out), 32'd0);
        chk("res_data", 32'(bus.if_data_out), 32'h22);
        nxt();
        idle_in();
        nxt();

        // Write into the I/O window.
        ma_set(1'b1, 32'h0003_0000, 8'h41);
        @(negedge clk);
        chk("io_we", 32'(bus.ram_we_out), IO_EN ? 32'd0 : 32'd1);
        chk("io_addr", 32'(bus.ram_addr_out), 32'h10000);
        nxt();
        idle_in();
        @(negedge clk);
        chk("io_valid", 32'(bus.io_valid_out), IO_EN ? 32'd1 : 32'd0);
        chk("io_data", 32'(bus.io_data_out), IO_EN ? 32'h41 : 32'h0);
        nxt();
        @(negedge clk);
        chk("io_valid_off", 32'(bus.io_valid_out), 32'd0);
        chk("io_data_hold", 32'(bus.io_data_out), IO_EN ? 32'h41 : 32'h0);
        nxt();
        ma_set(1'b0, 32'h10000, 8'h00);
        nxt();
        idle_in();
        @(negedge clk);
        chk("io_ram_rb", 32'(bus.ma_data_out), IO_EN ? 32'h0 : 32'h41);
        nxt();

        // Reset in the middle of a write burst.
        ma_set(1'b1, 32'h200, 8'h5A);
        @(negedge clk);
        chk("mid_we", 32'(bus.ram_we_out), 32'd1);
        nxt();
        rst = 1'b1;
        ma_set(1'b1, 32'h201, 8'h6B);
        @(negedge clk);
        chk("mid_rst_we", 32'(bus.ram_we_out), 32'd0);
        nxt();
        rst = 1'b0;
        idle_in();
        @(negedge clk);
        chk("post_if_data", 32'(bus.if_data_out), 32'h0);
        chk("post_ma_data", 32'(bus.ma_data_out), 32'h0);
        chk("post_io_valid", 32'(bus.io_valid_out), 32'd0);
        chk("post_io_data", 32'(bus.io_data_out), 32'h0);
        chk("post_stall", 32'(bus.if_stall_out), 32'd0);
        chk("post_addr", 32'(bus.ram_addr_out), 32'h0);
        nxt();
        bus.if_ce_in = 1'b1; bus.if_addr_in = 32'h10;
        @(negedge clk);
        chk("post_if_addr", 32'(bus.ram_addr_out), 32'h10);
        chk("post_if_stall", 32'(bus.if_stall_out), 32'd1);
        nxt();
        idle_in();
        @(negedge clk);
        chk("post_if_byte", 32'(bus.if_data_out), 32'hAB);
        nxt();

        // Read back: first write landed, reset-cycle writes did not.
        rb_adr = '{32'h200, 32'h201, 32'h20};
        rb_exp = '{8'h5A, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            if (i < 3) ma_set(1'b0, rb_adr[i], 8'h00);
            else       idle_in();
            @(negedge clk);
            if (i > 0) chk("rst_rb", 32'(bus.ma_data_out), 32'(rb_exp[i-1]));
            nxt();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter RAM_AW, default 17, RAM address width in bits.
REQ-002 Parameter IO_BASE, default 32'h0003_0000, lowest byte address of the I/O window.
REQ-003 Clock and reset: clk is the clock and rst is the reset, synchronous and active-high.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 if_addr_in  in  32  instruction-fetch byte address.
REQ-007 if_ce_in  in  1  instruction-fetch read request.
REQ-008 if_data_out  out  8  fetched byte.
REQ-009 if_stall_out  out  1  current fetch cycle not served; IF must hold its address.
REQ-010 ma_addr_in  in  32  data-port byte address.
REQ-011 ma_data_in  in  8  data-port write byte.
REQ-012 ma_rw_in  in  1  1 = write, 0 = read.
REQ-013 ma_ce_in  in  1  data-port request.
REQ-014 ma_data_out  out  8  data-port read byte.
REQ-015 ram_addr_out  out  RAM_AW  synchronous-RAM address.
REQ-016 ram_data_out  out  8  RAM write byte.
REQ-017 ram_we_out  out  1  RAM write enable.
REQ-018 ram_data_in  in  8  RAM read byte, valid one cycle after address.
REQ-019 io_data_out  out  8  I/O write byte.
REQ-020 io_valid_out  out  1  one-cycle I/O write strobe.

Function
REQ-021 Arbiter FSM states SRV_IDLE, SRV_IF, SRV_MA, SRV_TURN; the next state is evaluated at every posedge.
REQ-022 Transitions: ma_ce_in=1 goes to SRV_MA from any state; from SRV_MA with ma_ce_in=0, go to SRV_TURN; from SRV_TURN or SRV_IDLE, if_ce_in=1 goes to SRV_IF, otherwise SRV_IDLE; from SRV_IF with if_ce_in=0 and ma_ce_in=0, go to SRV_IDLE.
REQ-023 Port selection is combinational: when ma_ce_in=1, the data port owns the RAM in the same cycle (preemptive priority); otherwise the IF port owns it when if_ce_in=1 and state is not SRV_TURN.
REQ-024 ram_addr_out is the owner's address[RAM_AW-1:0]; upper address bits are ignored; when there is no owner it is 0.
REQ-025 ram_we_out = ma_ce_in & ma_rw_in & (address < IO_BASE); ram_data_out = ma_data_in.
REQ-026 Read latency is one cycle: an address held during cycle N yields data during cycle N+1.
REQ-027 A 2-bit owner tag rd_tag_q is registered each edge (NONE/IF/MA), recording which port issued the RAM read in that cycle.
REQ-028 ma_data_out = ram_data_in when rd_tag_q=MA; otherwise it holds the last MA byte.
REQ-029 if_data_out = ram_data_in when rd_tag_q=IF; otherwise it holds the last IF byte.
REQ-030 if_stall_out = if_ce_in & (ma_ce_in | state==SRV_TURN | rd_tag_q!=IF); it is deasserted only in cycles where if_data_out is valid for the previous IF address.
REQ-031 SRV_TURN lasts exactly one cycle and prevents the last MA read byte from being attributed to IF.
REQ-032 Simultaneous if_ce_in and ma_ce_in rising: MA is served and IF is stalled.
REQ-033 Writes produce no read tag; rd_tag_q is NONE after a write cycle.

Reset
REQ-034 On rst, state becomes SRV_IDLE and rd_tag_q becomes NONE.
REQ-035 On rst, both data-hold registers, io_data_out and io_valid_out become 0.
REQ-036 During rst, ram_we_out is 0 and if_stall_out is 0.
REQ-037 Reset mid-transaction abandons the transaction, and no RAM write occurs in the reset cycle.

Configuration
REQ-038 Macro MEM_CTRL_IO_EN defined: an MA write with address >= IO_BASE registers ma_data_in into io_data_out and pulses io_valid_out for one cycle; the RAM is not written.
REQ-039 Macro MEM_CTRL_IO_EN undefined: no I/O decode; all writes go to RAM at the truncated address; io_valid_out and io_data_out are tied 0.

Structure
REQ-040 The state encodings, owner-tag encodings and the IO_BASE default live in the shared define package alongside the existing bus-width macros.
REQ-041 A single sub-module, mem_ctrl_arb (FSM plus owner select), is natural; the data-hold and I/O logic stay in mem_ctrl.

Verification
REQ-042 IF read alone: RAM[0x10]=0xAB, if_addr=0x10, if_ce=1 -> next cycle if_data_out=0xAB, if_stall_out=0.
REQ-043 MA 4-byte write at 0x100 of 0x11223344, then LW-style read -> RAM bytes 44,33,22,11, and ma_data_out returns each byte one cycle after its address.
REQ-044 IF active when ma_ce rises -> same cycle ram_addr_out=MA address, if_stall_out=1, one SRV_TURN cycle after MA release, then IF resumes with the correct byte.
REQ-045 With MEM_CTRL_IO_EN, MA write 0x41 to 0x30000 -> io_valid_out=1 for one cycle, io_data_out=0x41, ram_we_out=0; without the macro -> RAM[0x10000]=0x41.
REQ-046 rst asserted mid MA write sequence -> ram_we_out=0 that cycle, state SRV_IDLE, all outputs zero next cycle.
